// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Holds the frame state encoding and the legal oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter for the UART receiver.
// edge_cnt runs 0..presc-1 per bit; wrap marks the last edge of a bit.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic               bit_clr,
    input  logic [PRESC_W-1:0] presc,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               wrap
);

    assign wrap = (edge_cnt == presc - PRESC_W'(1));

    // load marks edge 0 of the start bit, so the next edge is 1
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            edge_cnt <= PRESC_W'(1);
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_clr ? '0 : bit_cnt + BIT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing.
// Optional saturating error counter enabled by UART_RX_ERR_CNT_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  sample_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
`ifdef UART_RX_ERR_CNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 2);

    state_t                state;
    logic [PRESC_W-1:0]    presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_err_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [PRESC_W-1:0]    edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  wrap;
    logic [PRESC_W-1:0]    half;
    logic                  at_cap;
    logic                  legal;
    logic                  start_det;
    logic                  go_idle;
    logic                  last_data;

    assign legal = (Prescale == PRESC_W'(PRESC_8))
                || (Prescale == PRESC_W'(PRESC_16))
                || (Prescale == PRESC_W'(PRESC_32));

    assign half      = presc_q >> 1;
    assign at_cap    = (edge_cnt == half);
    assign start_det = (state == IDLE) && !RX_IN && legal;
    assign go_idle   = ((state == START) && at_cap && sampled_bit)
                    || ((state == STOP) && at_cap);
    assign last_data = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    assign busy      = (state != IDLE);
    assign sample_en = busy
                    && (edge_cnt >= half - PRESC_W'(2))
                    && (edge_cnt <= half);

    uart_rx_edge_bit_counter #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .clr      ((state == IDLE) || go_idle),
        .load     (start_det),
        .bit_clr  (state == START),
        .presc    (presc_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .wrap     (wrap)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err_q    <= 1'b0;
            shift_q      <= '0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
            err_cnt      <= '0;
`endif
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_det) begin
                        state     <= START;
                        presc_q   <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (at_cap && sampled_bit) begin
                        state <= IDLE;
`ifdef UART_RX_ERR_CNT_EN
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shift in from the top
                    if (at_cap)
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (wrap && last_data)
                        state <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (at_cap)
                        par_err_q <= sampled_bit != (^shift_q ^ par_typ_q);
                    if (wrap)
                        state <= STOP;
                end
                STOP: begin
                    if (at_cap) begin
                        state        <= IDLE;
                        stop_error   <= !sampled_bit;
                        parity_error <= par_err_q;
                        if (!par_err_q && sampled_bit) begin
                            data_valid <= 1'b1;
                            P_DATA     <= shift_q;
                        end
`ifdef UART_RX_ERR_CNT_EN
                        if ((par_err_q || !sampled_bit) && err_cnt != 8'hFF)
                            err_cnt <= err_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural 3-sample majority sampler.
// Checks latency, sample windows, error pulses, back-to-back frames and reset.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic       sample_en;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int chk_p    = 0;
    int se_bad   = 0;
    int se_hits  = 0;
    int dv_cnt   = 0;
    int dv_cyc   = 0;
    int dv_prev  = 0;
    int pe_cnt   = 0;
    int st_cnt   = 0;
    logic [1:0] hist;

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK          (clk),
        .RST          (rst),
        .RX_IN        (rx),
        .Prescale     (prescale),
        .PAR_EN       (par_en),
        .PAR_TYP      (par_typ),
        .sampled_bit  (sampled_bit),
        .sample_en    (sample_en),
        .P_DATA       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
`ifdef UART_RX_ERR_CNT_EN
        .err_cnt      (err_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) hist <= 2'b00;
        else if (sample_en) hist <= {hist[0], rx};
    end
    assign sampled_bit = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt  <= dv_cnt + 1;
            dv_prev <= dv_cyc;
            dv_cyc  <= cyc;
        end
        if (parity_error) pe_cnt <= pe_cnt + 1;
        if (stop_error) st_cnt <= st_cnt + 1;
        if (chk_p != 0 && (cyc - t0) < 11 * chk_p) begin
            se_bad  <= se_bad + int'(sample_en !==
                       (((cyc - t0) % chk_p >= chk_p / 2 - 2) &&
                        ((cyc - t0) % chk_p <= chk_p / 2)));
            se_hits <= se_hits + int'(sample_en);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // caller is aligned 1 time unit after a rising edge
    task automatic send(input logic [7:0] d, input int p, input logic pe,
                        input logic pb, input logic sb, input int nb);
        logic [10:0] bits;
        int len;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) begin
            bits[9] = pb;
            bits[10] = sb;
            len = 11;
        end else begin
            bits[9] = sb;
            len = 10;
        end
        t0 = cyc;
        for (int i = 0; i < len && i < nb; i++) begin
            rx = bits[i];
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int bh;
        rst = 1'b1;
        rx = 1'b1;
        prescale = 6'd8;
        par_en = 1'b1;
        par_typ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_pdata", p_data, 0);
        chk("rst_se", sample_en, 0);
        chk("rst_errs", {parity_error, stop_error}, 0);
`ifdef UART_RX_ERR_CNT_EN
        chk("rst_errcnt", err_cnt, 0);
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk_p = 8;
        send(8'hA5, 8, 1'b1, 1'b0, 1'b1, 99);
        chk_p = 0;
        chk("a5_latency", dv_cyc - t0, 85);
        chk("a5_se_window", se_bad, 0);
        chk("a5_se_count", se_hits, 33);
        chk("a5_pdata", p_data, 8'hA5);
        chk("a5_dv_cnt", dv_cnt, 1);
        chk("a5_errs", pe_cnt + st_cnt, 0);

        prescale = 6'd16;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("fs_busy_mid", busy, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("fs_busy_end", busy, 0);
        chk("fs_dv_cnt", dv_cnt, 1);
        chk("fs_errs", pe_cnt + st_cnt, 0);
        chk("fs_pdata", p_data, 8'hA5);
`ifdef UART_RX_ERR_CNT_EN
        chk("fs_errcnt", err_cnt, 1);
`endif

        par_typ = 1'b1;
        send(8'h3C, 16, 1'b1, 1'b0, 1'b1, 99);
        chk("par_pe_cnt", pe_cnt, 1);
        chk("par_st_cnt", st_cnt, 0);
        chk("par_dv_cnt", dv_cnt, 1);
        chk("par_pdata", p_data, 8'hA5);
`ifdef UART_RX_ERR_CNT_EN
        chk("par_errcnt", err_cnt, 2);
`endif

        prescale = 6'd8;
        par_en = 1'b0;
        send(8'h81, 8, 1'b0, 1'b0, 1'b0, 99);
        rx = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        chk("stp_st_cnt", st_cnt, 1);
        chk("stp_pe_cnt", pe_cnt, 1);
        chk("stp_dv_cnt", dv_cnt, 1);
        chk("stp_busy", busy, 0);
`ifdef UART_RX_ERR_CNT_EN
        chk("stp_errcnt", err_cnt, 4);
`endif
        send(8'h7E, 8, 1'b0, 1'b0, 1'b1, 99);
        chk("7e_pdata", p_data, 8'h7E);
        chk("7e_dv_cnt", dv_cnt, 2);
        chk("7e_st_cnt", st_cnt, 1);

        prescale = 6'd32;
        send(8'h55, 32, 1'b0, 1'b0, 1'b1, 99);
        send(8'hAA, 32, 1'b0, 1'b0, 1'b1, 99);
        chk("b2b_dv_cnt", dv_cnt, 4);
        chk("b2b_spacing", dv_cyc - dv_prev, 320);
        chk("b2b_pdata", p_data, 8'hAA);

        prescale = 6'd8;
        send(8'h34, 8, 1'b0, 1'b0, 1'b1, 5);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_se", sample_en, 0);
        chk("mrst_pdata", p_data, 0);
        chk("mrst_outs", {data_valid, parity_error, stop_error}, 0);
`ifdef UART_RX_ERR_CNT_EN
        chk("mrst_errcnt", err_cnt, 0);
`endif
        rst = 1'b0;
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(8'h12, 8, 1'b0, 1'b0, 1'b1, 99);
        chk("12_pdata", p_data, 8'h12);
        chk("12_dv_cnt", dv_cnt, 5);

        prescale = 6'd12;
        rx = 1'b0;
        bh = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            bh += int'(busy);
        end
        rx = 1'b1;
        chk("ill_busy", bh, 0);
        chk("ill_dv_cnt", dv_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
